// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the round-robin multiplier scheduler.
//   state_t          : scheduler FSM states (IDLE, RUN, CAPT, RESP)
//   PROD_W / OPND_W  : product and operand widths of the shared multiplier
//   DEF_TIMEOUT_CYC  : default number of RUN cycles before a transaction aborts
//   is_zero_opnd()   : true when either operand is zero (zero-bypass decision)
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int PROD_W          = 64;
  localparam int OPND_W          = 32;
  localparam int DEF_TIMEOUT_CYC = 48;

  function automatic logic is_zero_opnd(input logic [OPND_W-1:0] a,
                                        input logic [OPND_W-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches upward from i_ptr+1, wrapping
// modulo NREQ, and returns the first requester found.
// Ports:
//   i_req  [NREQ-1:0] : request vector
//   i_ptr  [IDW-1:0]  : index of the requester served last (lowest priority)
//   o_gnt  [NREQ-1:0] : one-hot grant (all zero when no request)
//   o_idx  [IDW-1:0]  : index of the granted requester
//   o_any             : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Priority distance of each requester from the pointer: 0 = ptr+1, the
  // highest priority, NREQ-1 = ptr itself. One extra bit holds j+NREQ-1-ptr,
  // which stays below 2*NREQ, so a single conditional subtract wraps it.
  logic [IDW:0]    w_dist [NREQ];
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;

  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      w_dist[j] = (IDW+1)'(j + NREQ - 1) - {1'b0, i_ptr};
      if (w_dist[j] >= (IDW+1)'(NREQ)) begin
        w_dist[j] = w_dist[j] - (IDW+1)'(NREQ);
      end
    end
  end

  // Walk distances in priority order; all indices are loop constants so the
  // search flattens into a small priority network.
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int d = 0; d < NREQ; d++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_any && i_req[j] && (w_dist[j] == (IDW+1)'(d))) begin
          w_any    = 1'b1;
          w_gnt[j] = 1'b1;
          w_idx    = IDW'(j);
        end
      end
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;
  assign o_any = w_any;

endmodule

// File: rtl/mult_rr_sched.sv
// -----------------------------------------------------------------------------
// mult_rr_sched
// Round-robin scheduler sharing one iterative signed 32x32 multiplier among
// NREQ requesters. Grants one requester at a time, drives the multiplier's
// level-held start/valid protocol, captures the 64-bit product and returns it
// with the requester ID on a valid/ready response port.
//
// Optional feature: define MULT_RR_ZERO_BYPASS_EN to answer transactions with
// a zero operand directly (product 0, one cycle after grant) without starting
// the multiplier. Undefined: zero operands go through the multiplier.
//
// Ports:
//   i_clock, i_reset     : clock (rising edge), async active-high reset
//   i_req_valid [NREQ]   : per-requester request, held until granted
//   o_req_ready [NREQ]   : one-hot grant pulse, operands taken this cycle
//   i_req_mlier/mcand    : packed operands, slice i = [32*i+31:32*i]
//   o_rsp_valid/i_rsp_ready : response handshake
//   o_rsp_id/prodt/err   : response requester index, product, timeout flag
//   o_mul_start          : level-held multiplier start
//   o_mul_mlier/mcand    : operands to multiplier, stable during RUN
//   i_mul_prodt/valid    : multiplier product and completion flag
//   o_busy               : scheduler not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// RUN   | multiplier started, waiting for mul_valid or timeout
// CAPT  | one cycle for the multiplier to register its product
// RESP  | response presented, held until accepted
// -----------------------------------------------------------------------------
module mult_rr_sched
  import mult_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NREQ-1:0]        i_req_valid,
  output logic [NREQ-1:0]        o_req_ready,
  input  logic [NREQ*OPND_W-1:0] i_req_mlier,
  input  logic [NREQ*OPND_W-1:0] i_req_mcand,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [PROD_W-1:0]      o_rsp_prodt,
  output logic                   o_rsp_err,
  output logic                   o_mul_start,
  output logic [OPND_W-1:0]      o_mul_mlier,
  output logic [OPND_W-1:0]      o_mul_mcand,
  input  logic [PROD_W-1:0]      i_mul_prodt,
  input  logic                   i_mul_valid,
  output logic                   o_busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              r_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic [IDW-1:0]      r_rsp_id;
  logic [PROD_W-1:0]   r_rsp_prodt;
  logic                r_rsp_err;
  logic                r_mul_start;
  logic [OPND_W-1:0]   r_mul_mlier;
  logic [OPND_W-1:0]   r_mul_mcand;

  logic [NREQ-1:0]     w_gnt;
  logic [IDW-1:0]      w_idx;
  logic                w_any;
  logic [OPND_W-1:0]   w_sel_mlier;
  logic [OPND_W-1:0]   w_sel_mcand;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    w_sel_mlier = '0;
    w_sel_mcand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_mlier = i_req_mlier[i*OPND_W +: OPND_W];
        w_sel_mcand = i_req_mcand[i*OPND_W +: OPND_W];
      end
    end
  end

`ifdef MULT_RR_ZERO_BYPASS_EN
  logic w_zero;
  assign w_zero = is_zero_opnd(w_sel_mlier, w_sel_mcand);
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_prodt <= '0;
      r_rsp_err   <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_mlier <= '0;
      r_mul_mcand <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rr_ptr    <= w_idx;
            r_rsp_id    <= w_idx;
            r_mul_mlier <= w_sel_mlier;
            r_mul_mcand <= w_sel_mcand;
            r_cnt       <= '0;
`ifdef MULT_RR_ZERO_BYPASS_EN
            if (w_zero) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_prodt <= '0;
              r_rsp_err   <= 1'b0;
            end else begin
              r_state     <= RUN;
              r_mul_start <= 1'b1;
            end
`else
            r_state     <= RUN;
            r_mul_start <= 1'b1;
`endif
          end
        end

        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Completion wins over a timeout landing on the same cycle.
          if (i_mul_valid) begin
            r_state <= CAPT;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= RESP;
            r_mul_start <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_prodt <= '0;
            r_rsp_err   <= 1'b1;
          end
        end

        // The multiplier's product register lags valid by one cycle, so
        // start stays high here and the product is taken at the end.
        CAPT: begin
          r_state     <= RESP;
          r_mul_start <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_prodt <= i_mul_prodt;
          r_rsp_err   <= 1'b0;
        end

        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_mul_start <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Grant is only offered in IDLE; it lands on the same edge that loads the
  // operand registers and the round-robin pointer.
  assign o_req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_prodt = r_rsp_prodt;
  assign o_rsp_err   = r_rsp_err;
  assign o_mul_start = r_mul_start;
  assign o_mul_mlier = r_mul_mlier;
  assign o_mul_mcand = r_mul_mcand;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched: directed scenarios plus randomized
// traffic against a transaction-level reference model (rotation order,
// signed product, timeout, latency).
module tb_mult_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 48;
`ifdef MULT_RR_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    pend;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_mlier;
  logic [NREQ*32-1:0] req_mcand;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_prodt;
  logic               rsp_err;
  logic               mul_start;
  logic [31:0]        mul_mlier;
  logic [31:0]        mul_mcand;
  logic [63:0]        m_prod;
  logic               mul_valid;
  logic               busy;

  logic [31:0] opa [NREQ];
  logic [31:0] opb [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_mlier = '0;
    req_mcand = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_mlier[i*32 +: 32] = opa[i];
      req_mcand[i*32 +: 32] = opb[i];
    end
  end

  mult_rr_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req_valid (pend),
    .o_req_ready (req_ready),
    .i_req_mlier (req_mlier),
    .i_req_mcand (req_mcand),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_prodt (rsp_prodt),
    .o_rsp_err   (rsp_err),
    .o_mul_start (mul_start),
    .o_mul_mlier (mul_mlier),
    .o_mul_mcand (mul_mcand),
    .i_mul_prodt (m_prod),
    .i_mul_valid (mul_valid),
    .o_busy      (busy)
  );

  // Iterative multiplier model: valid (level) after lat cycles of start,
  // product registered one cycle after valid, cleared when start drops.
  int m_cnt;
  int lat  = 3;
  bit hang = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else begin
      m_cnt <= mul_start ? m_cnt + 1 : 0;
      if (mul_valid) m_prod <= longint'($signed(mul_mlier)) * longint'($signed(mul_mcand));
      else if (!mul_start) m_prod <= '0;
    end
  end
  assign mul_valid = mul_start && !hang && (m_cnt >= lat - 1);

  // Reference model state
  typedef struct {
    int          id;
    logic [63:0] prod;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          served[$];
  int          last = NREQ - 1;
  int          ncyc = 0;
  int          grant_cyc = 0;
  bit          rsp_first = 1'b0;
  bit          start_seen = 1'b0;
  bit          done_start_seen = 1'b0;
  bit          rand_lat = 1'b0;
  logic [63:0] last_prod;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic new_req(input int i, input logic [31:0] a, input logic [31:0] b);
    opa[i]  = a;
    opb[i]  = b;
    pend[i] = 1'b1;
  endtask

  // One clock: observe and check at the falling edge, apply consequences
  // just after the rising edge.
  task automatic cycle();
    int g;
    int pick;
    bit gv;
    exp_t e;
    @(negedge clk);
    ncyc++;
    gv = 1'b0;
    g  = 0;
    if (mul_start) start_seen = 1'b1;
    if (req_ready != '0) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && pend[(last + k) % NREQ]) pick = (last + k) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      chk("gnt_onehot", $countones(req_ready), 1);
      chk("gnt_id", g, pick);
      if (pick >= 0) begin
        if (rand_lat) lat = $urandom_range(1, 8);
        e.id = pick;
        if (BYP && (opa[pick] == 0 || opb[pick] == 0)) begin
          e.prod = 0; e.err = 1'b0; e.lat = 1;
        end else if (hang) begin
          e.prod = 0; e.err = 1'b1; e.lat = TO + 1;
        end else begin
          e.prod = longint'($signed(opa[pick])) * longint'($signed(opb[pick]));
          e.err  = 1'b0;
          e.lat  = lat + 2;
        end
        q.push_back(e);
        last = pick;
      end
      gv         = 1'b1;
      grant_cyc  = ncyc;
      start_seen = 1'b0;
      rsp_first  = 1'b0;
    end
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 1, 0);
      end else begin
        if (!rsp_first) begin
          chk("latency", ncyc - grant_cyc, q[0].lat);
          chk("start_in_resp", mul_start, 0);
          rsp_first = 1'b1;
        end
        if (rsp_ready) begin
          chk("rsp_id", rsp_id, q[0].id);
          chk("rsp_prodt", rsp_prodt, q[0].prod);
          chk("rsp_err", rsp_err, q[0].err);
          served.push_back(q[0].id);
          last_prod       = rsp_prodt;
          done_start_seen = start_seen;
          void'(q.pop_front());
          rsp_first = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (gv) pend[g] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend != '0 || q.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", (n < budget), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    pend = '0; q.delete(); last = NREQ - 1; rsp_first = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_id"}, rsp_id, 0);
    chk({pfx, "_rsp_prodt"}, rsp_prodt, 0);
    chk({pfx, "_rsp_err"}, rsp_err, 0);
    chk({pfx, "_mul_start"}, mul_start, 0);
    chk({pfx, "_mul_mlier"}, mul_mlier, 0);
    chk({pfx, "_mul_mcand"}, mul_mcand, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int rv;
    pend = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end

    // Reset values with reset held
    #12;
    check_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: single request, 7 * -3
    lat = 3;
    new_req(0, 32'd7, 32'hFFFF_FFFD);
    drain(100);
    chk("t1_prod_const", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t1_served", served[served.size()-1], 0);

    // 2: all four at once from a fresh pointer, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      served.delete();
      for (int i = 0; i < NREQ; i++) new_req(i, $urandom(), $urandom());
      drain(200);
      chk("t2_count", served.size(), NREQ);
      for (int i = 0; i < NREQ && i < served.size(); i++) chk("t2_order", served[i], i);
    end

    // 3: response stall with another request waiting
    rsp_ready = 1'b0;
    new_req(2, $urandom(), $urandom());
    n = 0;
    while (!rsp_valid && n < 100) begin cycle(); n++; end
    chk("t3_rsp_seen", rsp_valid, 1);
    new_req(1, $urandom(), $urandom());
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_prodt", rsp_prodt, (q.size() != 0) ? q[0].prod : 64'hDEAD);
      chk("t3_no_grant", req_ready, 0);
      chk("t3_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    drain(100);

    // 4: multiplier never completes -> timeout, then a normal transaction
    hang = 1'b1;
    new_req(3, 32'd11, 32'd13);
    drain(200);
    chk("t4_err_flag", rsp_err, 1);
    hang = 1'b0;
    new_req(0, 32'd100, 32'hFFFF_FF00);
    drain(100);
    chk("t4_after_err", rsp_err, 0);

    // 5: reset in RUN
    lat = 20;
    new_req(2, $urandom(), $urandom());
    n = 0;
    while (!mul_start && n < 50) begin cycle(); n++; end
    repeat (3) cycle();
    chk("t5_in_run", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("t5");
    q.delete(); pend = '0; last = NREQ - 1; rsp_first = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rv = 0;
    for (int i = 0; i < 10; i++) begin cycle(); rv += int'(rsp_valid); end
    chk("t5_no_rsp", rv, 0);
    lat = 3;

    // 6: zero operand
    new_req(1, 32'd0, 32'd5);
    drain(100);
    chk("t6_prod", last_prod, 0);
    chk("t6_start_seen", done_start_seen, BYP ? 0 : 1);

    // Randomized traffic with stalls, drops and varying multiplier latency
    rand_lat = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 5) == 0) new_req(i, rand_opnd(), rand_opnd());
      end
      if ($urandom_range(0, 15) == 0) pend[$urandom_range(0, NREQ-1)] = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rsp_ready = 1'b1;
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_rr_sched.md
Name: mult_rr_sched

Overview:
- Round-robin scheduler that shares one iterative signed 32x32 multiplier among NREQ requesters.
- Sequences the multiplier's level-held start/valid protocol, captures the 64-bit product and returns it with the requester ID over a valid/ready response port.
- Sits between the requester-side datapath blocks and a single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- TIMEOUT_CYC, 48, maximum cycles in RUN before an abort.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant pulse; operands accepted on this cycle.
- req_mlier  in  NREQ*32  packed multipliers; slice i = [32*i+31:32*i].
- req_mcand  in  NREQ*32  packed multiplicands.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_prodt  out  64  signed product.
- rsp_err  out  1  response came from a timeout abort.
- mul_start  out  1  level-held start to the multiplier.
- mul_mlier  out  32  operand to the multiplier, held stable during RUN.
- mul_mcand  out  32  operand to the multiplier, held stable during RUN.
- mul_prodt  in  64  multiplier product.
- mul_valid  in  1  multiplier completion flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_prodt=0; rsp_err=0; mul_start=0; mul_mlier=0; mul_mcand=0; rr_ptr=NREQ-1; timeout counter=0; busy=0.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr+1, wrapping modulo NREQ.
  - Pulse req_ready[g] for exactly one cycle; latch that requester's operands into mul_mlier/mul_mcand; set rr_ptr=g; go to RUN.
  - req_ready is combinational from state, req_valid and rr_ptr. The registered grant updates on the same edge.
- RUN:
  - mul_start=1 from the first RUN cycle; operands constant throughout.
  - Counter increments each cycle.
  - On the first cycle mul_valid=1, go to CAPT.
  - If the counter reaches TIMEOUT_CYC first, set rsp_prodt=0, rsp_err=1, go to RESP.
- CAPT:
  - One cycle with mul_start still 1, because the multiplier registers its product one cycle after valid.
  - At the end of CAPT: rsp_prodt<=mul_prodt, rsp_err<=0, go to RESP.
- RESP:
  - mul_start=0, so the multiplier clears.
  - rsp_valid=1; rsp_id/rsp_prodt/rsp_err held stable until rsp_valid && rsp_ready, then go to IDLE.
  - mul_start is low for at least two cycles (RESP and IDLE) before the next RUN.
- Latency: grant to rsp_valid = multiplier completion cycles + 2.
- Requests arriving while busy wait; req_valid must stay high until req_ready. Only one transaction is in flight.
- Simultaneous requests: strict rotation. The requester just served has lowest priority next round.
- req_valid dropped before grant: no grant is issued, and no state is held for that requester.
- Reset mid-operation: everything returns to reset values immediately, mul_start drops, and any in-flight result is discarded.
- rsp_ready high with rsp_valid low has no effect.

Optional Feature:
- MULT_RR_ZERO_BYPASS_EN defined:
  - In IDLE, if the selected mlier==0 or mcand==0, go directly to RESP with rsp_prodt=0 and rsp_err=0.
  - mul_start is never raised for that transaction; latency from grant to rsp_valid is 1.
- Undefined: zero operands go through the multiplier like any other operands.

Decomposition:
- Shared package mult_pkg holds:
  - state enum {IDLE, RUN, CAPT, RESP};
  - PROD_W=64, OPND_W=32;
  - the default TIMEOUT_CYC.
- One natural sub-module, rr_arbiter: combinational round-robin pick taking req vector and pointer, returning one-hot grant and index.

Test Plan:
1. Single request 0, mlier=7, mcand=-3 -> rsp_id=0, rsp_prodt=64'hFFFF_FFFF_FFFF_FFEB, rsp_err=0; mul_start low in RESP.
2. All four requests at once with distinct operands, rsp_ready=1 -> responses in order 0,1,2,3; a repeat burst yields 0,1,2,3 again.
3. Response stall: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_prodt held stable, no new grant, busy=1; accepted when rsp_ready=1.
4. Multiplier model never asserts mul_valid -> after 48 RUN cycles rsp_err=1, rsp_prodt=0; next request completes normally.
5. Reset asserted in RUN -> same-cycle mul_start=0 and busy=0; outputs at reset values; no response emitted.
6. With MULT_RR_ZERO_BYPASS_EN, mlier=0, mcand=5 -> rsp_prodt=0 one cycle after grant, mul_start never asserted.
